svpwm_cmp_convert: RTL
======================

// Module: svpwm_cmp_convert
// PURPOSE
//  Converts N_CH IEEE-754 single-precision SVPWM compare values to unsigned OUT_W-bit
//  integers for the PWM timer. Sits between the float SVPWM core and the counter/compare
//  stage. One shared, pipelined converter is time-multiplexed over channels. All outputs
//  update in the same cycle (glitch-free compare reload).
// PARAMETERS
//  N_CH   3   number of compare channels (1..8)
//  OUT_W  16  output integer width (8..24)
// PORTS
//  sys_clk   in   1          system clock, rising edge
//  rst       in   1          synchronous reset, active-high
//  en        in   1          start request; sampled only in IDLE
//  cp_f      in   32*N_CH    packed fp32 inputs, channel i at [32*i+31:32*i]
//  cp        out  OUT_W*N_CH packed unsigned results, channel i at [OUT_W*i+OUT_W-1:OUT_W*i]
//  ack       out  1          one-cycle pulse: cp updated this cycle
//  busy      out  1          high from the cycle after en is accepted through the ack cycle
//  sat       out  N_CH       per-channel clamp flag (only with CMP_SAT_STATUS_EN)
// BEHAVIOUR
//  Reset: cp=0, ack=0, busy=0, sat=0, FSM=IDLE, channel counter=0, pipeline valids=0.
//  FSM: IDLE -> FEED -> DRAIN -> DONE -> IDLE.
//   IDLE:  en=1 captures all of cp_f into an input register -> FEED.
//   FEED:  issues channel idx 0..N_CH-1, one per cycle; after idx N_CH-1 -> DRAIN.
//   DRAIN: waits for the converter to deliver the last result (converter latency 2) -> DONE.
//   DONE:  copies the shadow results to cp, ack=1 for this cycle -> IDLE.
//  Latency: en accepted at edge 0 -> ack high in cycle N_CH+3 (N_CH=3: 6 cycles).
//  en while busy: ignored, not queued. cp_f changes after capture do not affect results.
//  Back-to-back: en high in the cycle after ack starts a new conversion.
//  Conversion: round to nearest, ties away from zero.
//   exp==0 (zero/denormal), or +value<0.5  -> 0
//   sign=1 and nonzero magnitude           -> 0, clamp
//   -0.0                                   -> 0, no clamp
//   NaN                                    -> 0, clamp
//   +Inf, or rounded value >= 2^OUT_W      -> 2^OUT_W-1, clamp
//   otherwise: mant={1,frac}, shift by (exp-127-23), add round bit.
//   Saturate after rounding (e.g. 65535.5 -> 65535, clamp).
//  Converter stages: stage 1 decodes and classifies; stage 2 shifts, rounds, saturates.
//   The channel index travels with each valid bit.
//  Reset mid-operation: abort and return to IDLE with reset values. The shadow is
//   discarded; cp stays 0 until the next DONE.
// CONFIGURATION
//  CMP_SAT_STATUS_EN defined: sat port exists. sat[i] gets channel i's clamp flag and
//   updates with cp in the ack cycle. sat holds its value until the next ack or reset.
//  Not defined: no sat port; clamp logic still saturates, but flags are not stored.
// STRUCTURE
//  Package svpwm_pkg: FP32_EXP_W=8, FP32_FRAC_W=23, FP32_BIAS=127; fsm state typedef
//   (IDLE, FEED, DRAIN, DONE); function/typedef for fp32 field unpacking.
//  Sub-module fp32_to_uint_pipe #(OUT_W): 2-stage converter.
//   in: valid, idx, data; out: valid, idx, result, clamp.
//  Top: FSM, channel counter, input capture register, shadow/output registers.
// TESTING
//  1 N_CH=3; cp_f={0x447A0000,0x40200000,0x3EFAE148} (1000.0, 2.5, 0.49) ->
//    cp={1000,3,0}, ack exactly at cycle 6, busy high for cycles 1..6.
//  2 {0x4788B800,0xBF800000,0x7FC00000} (70000.0, -1.0, NaN) -> cp={65535,0,0};
//    with CMP_SAT_STATUS_EN sat=3'b111.
//  3 {0x3F000000,0x80000000,0x477FFF80} (0.5, -0.0, 65535.5) -> cp={1,0,65535};
//    sat=3'b100.
//  4 en held high for 20 cycles -> ack every 7 cycles; cp_f changed mid-run is not
//    reflected until the next capture.
//  5 rst at cycle 3 of a run -> next cycle cp=0, ack=0, busy=0; no ack follows.
//    A fresh en converts correctly.
//  6 N_CH=1, OUT_W=8: 0x43800000 (256.0) -> 255, clamp;
//    0x437F0000 (255.0) -> 255, no clamp.

Source files
------------

// File: rtl/svpwm_pkg.sv
// rtl/svpwm_pkg.sv - shared fp32 field constants, FSM and class typedefs for the SVPWM compare converter
package svpwm_pkg;

  localparam int FP32_EXP_W  = 8;
  localparam int FP32_FRAC_W = 23;
  localparam int FP32_BIAS   = 127;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FEED,
    ST_DRAIN,
    ST_DONE
  } cmp_state_e;

  // Outcome of stage-1 classification; only CLS_NUM needs the shifter.
  typedef enum logic [1:0] {
    CLS_ZERO,
    CLS_ZERO_CLAMP,
    CLS_MAX,
    CLS_NUM
  } fp_class_e;

  typedef struct packed {
    logic                   sign;
    logic [FP32_EXP_W-1:0]  exp;
    logic [FP32_FRAC_W-1:0] frac;
  } fp32_t;

  function automatic fp32_t fp32_unpack(input logic [31:0] raw);
    fp32_t f;
    f.sign = raw[31];
    f.exp  = raw[30:23];
    f.frac = raw[22:0];
    return f;
  endfunction

endpackage

// File: rtl/fp32_to_uint_pipe.sv
// rtl/fp32_to_uint_pipe.sv - 2-stage fp32 to unsigned OUT_W converter, round half away from zero, saturating
module fp32_to_uint_pipe
  import svpwm_pkg::*;
#(
  parameter int OUT_W = 16,
  parameter int IDX_W = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  input  logic [IDX_W-1:0] in_idx_i,
  input  logic [31:0]      in_data_i,
  output logic             out_valid_o,
  output logic [IDX_W-1:0] out_idx_o,
  output logic [OUT_W-1:0] out_result_o,
  output logic             out_clamp_o
);

  localparam int MANT_W = FP32_FRAC_W + 1;
  // Biased exponent at which the 24-bit mantissa is already an integer.
  localparam logic [7:0] SH_BASE  = 8'(FP32_BIAS + FP32_FRAC_W);
  // Below this exponent the value is < 0.5 and rounds to 0.
  localparam logic [7:0] HALF_EXP = 8'(FP32_BIAS - 1);
  // At or above this exponent the value is >= 2^OUT_W.
  localparam logic [8:0] BIG_EXP  = 9'(FP32_BIAS + OUT_W);

  fp32_t             in_f;
  fp_class_e         cls_d, s1_cls_q;
  logic [4:0]        sh_d, s1_sh_q;
  logic [MANT_W-1:0] mant_d, s1_mant_q;
  logic              s1_valid_q;
  logic [IDX_W-1:0]  s1_idx_q;

  logic [MANT_W:0]   ext;
  logic [MANT_W:0]   rounded;
  logic [OUT_W-1:0]  res_d;
  logic              clamp_d;

  assign in_f = fp32_unpack(in_data_i);

  // Stage 1: classify specials and compute the right-shift for the normal path
  always_comb begin
    cls_d  = CLS_NUM;
    sh_d   = '0;
    mant_d = {1'b1, in_f.frac};
    if (in_f.exp == '0) begin
      cls_d = CLS_ZERO;
    end else if (in_f.exp == '1 && in_f.frac != '0) begin
      cls_d = CLS_ZERO_CLAMP;
    end else if (in_f.sign) begin
      cls_d = CLS_ZERO_CLAMP;
    end else if (in_f.exp == '1) begin
      cls_d = CLS_MAX;
    end else if (in_f.exp < HALF_EXP) begin
      cls_d = CLS_ZERO;
    end else if ({1'b0, in_f.exp} >= BIG_EXP) begin
      cls_d = CLS_MAX;
    end else begin
      sh_d = 5'(SH_BASE - in_f.exp);
    end
  end

  // Stage 1 register; channel index travels with the valid bit
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      s1_idx_q   <= '0;
      s1_cls_q   <= CLS_ZERO;
      s1_sh_q    <= '0;
      s1_mant_q  <= '0;
    end else begin
      s1_valid_q <= in_valid_i;
      s1_idx_q   <= in_idx_i;
      s1_cls_q   <= cls_d;
      s1_sh_q    <= sh_d;
      s1_mant_q  <= mant_d;
    end
  end

  // Stage 2: shift keeping one guard bit, add it back as the round bit, then saturate
  always_comb begin
    ext     = {s1_mant_q, 1'b0} >> s1_sh_q;
    rounded = {1'b0, ext[MANT_W:1]} + (MANT_W + 1)'(ext[0]);
    res_d   = '0;
    clamp_d = 1'b0;
    unique case (s1_cls_q)
      CLS_ZERO:       res_d = '0;
      CLS_ZERO_CLAMP: clamp_d = 1'b1;
      CLS_MAX: begin
        res_d   = '1;
        clamp_d = 1'b1;
      end
      CLS_NUM: begin
        if ((rounded >> OUT_W) != '0) begin
          res_d   = '1;
          clamp_d = 1'b1;
        end else begin
          res_d = rounded[OUT_W-1:0];
        end
      end
      default: res_d = '0;
    endcase
  end

  // Stage 2 register drives the converter outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_o  <= 1'b0;
      out_idx_o    <= '0;
      out_result_o <= '0;
      out_clamp_o  <= 1'b0;
    end else begin
      out_valid_o  <= s1_valid_q;
      out_idx_o    <= s1_idx_q;
      out_result_o <= res_d;
      out_clamp_o  <= clamp_d;
    end
  end

endmodule

// File: rtl/svpwm_cmp_convert.sv
// rtl/svpwm_cmp_convert.sv - time-multiplexed fp32 to uint compare converter; CMP_SAT_STATUS_EN adds the sat port
module svpwm_cmp_convert
  import svpwm_pkg::*;
#(
  parameter int N_CH  = 3,
  parameter int OUT_W = 16
) (
  input  logic                  sys_clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [32*N_CH-1:0]    cp_f,
  output logic [OUT_W*N_CH-1:0] cp,
  output logic                  ack,
  output logic                  busy
`ifdef CMP_SAT_STATUS_EN
  ,
  output logic [N_CH-1:0]       sat
`endif
);

  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CH - 1);

  cmp_state_e              state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [32*N_CH-1:0]      cap_q;
  logic                    cap_load;
  logic [OUT_W*N_CH-1:0]   shadow_q, shadow_d;
  logic [OUT_W*N_CH-1:0]   cp_q;
  logic                    cp_load;

  logic                    pipe_in_valid;
  logic [31:0]             pipe_in_data;
  logic                    out_valid;
  logic [IDX_W-1:0]        out_idx;
  logic [OUT_W-1:0]        out_result;
  logic                    out_clamp;
  logic                    last_done;

  assign last_done = out_valid && (out_idx == LAST_IDX);
  // cp reloads on the edge into DONE so it is visible together with ack.
  assign cp_load   = (state_q == ST_DRAIN) && last_done;

  // Next-state logic: capture, feed one channel per cycle, drain, publish
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cap_load = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d  = ST_FEED;
          idx_d    = '0;
          cap_load = 1'b1;
        end
      end
      ST_FEED: begin
        if (idx_q == LAST_IDX) begin
          state_d = ST_DRAIN;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_DRAIN: begin
        if (last_done) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register, channel counter and input capture register
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cap_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (cap_load) begin
        cap_q <= cp_f;
      end
    end
  end

  // Select the captured word of the channel being issued
  always_comb begin
    pipe_in_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (idx_q == IDX_W'(i)) begin
        pipe_in_data = cap_q[32*i +: 32];
      end
    end
  end

  assign pipe_in_valid = (state_q == ST_FEED);

  fp32_to_uint_pipe #(
    .OUT_W (OUT_W),
    .IDX_W (IDX_W)
  ) u_conv (
    .clk_i        (sys_clk),
    .rst_i        (rst),
    .in_valid_i   (pipe_in_valid),
    .in_idx_i     (idx_q),
    .in_data_i    (pipe_in_data),
    .out_valid_o  (out_valid),
    .out_idx_o    (out_idx),
    .out_result_o (out_result),
    .out_clamp_o  (out_clamp)
  );

  // Merge the converter result into its channel slot of the shadow
  always_comb begin
    shadow_d = shadow_q;
    for (int i = 0; i < N_CH; i++) begin
      if (out_valid && out_idx == IDX_W'(i)) begin
        shadow_d[OUT_W*i +: OUT_W] = out_result;
      end
    end
  end

  // Shadow and output compare registers; all channels reload together
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      shadow_q <= '0;
      cp_q     <= '0;
    end else begin
      shadow_q <= shadow_d;
      if (cp_load) begin
        cp_q <= shadow_d;
      end
    end
  end

`ifdef CMP_SAT_STATUS_EN
  logic [N_CH-1:0] clamp_sh_q, clamp_sh_d, sat_q;

  // Merge the converter clamp flag into its channel slot
  always_comb begin
    clamp_sh_d = clamp_sh_q;
    for (int i = 0; i < N_CH; i++) begin
      if (out_valid && out_idx == IDX_W'(i)) begin
        clamp_sh_d[i] = out_clamp;
      end
    end
  end

  // Clamp shadow and sat register, reloaded alongside cp
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      clamp_sh_q <= '0;
      sat_q      <= '0;
    end else begin
      clamp_sh_q <= clamp_sh_d;
      if (cp_load) begin
        sat_q <= clamp_sh_d;
      end
    end
  end

  assign sat = sat_q;
`else
  logic unused_clamp;
  assign unused_clamp = out_clamp;
`endif

  assign cp   = cp_q;
  assign ack  = (state_q == ST_DONE);
  assign busy = (state_q != ST_IDLE);

endmodule
